busca_instrucao: RTL and testbench

- Multi-cycle instruction fetch stage for the 8-bit processor.
- Holds the PC and fetches each 8-bit instruction from instruction memory over a req/ack handshake.
- Latches the instruction into an instruction register (IR) and drives OPcode/BitVerificao into the control unit.
- Uses the returned Jump/Beqz/Halt decisions to select the next PC.

---
 rtl/busca_instrucao_if.sv | 31 +++
 rtl/busca_instrucao.sv | 136 +++++++++++++
 tb/tb_busca_instrucao.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/busca_instrucao_if.sv
// ============================================================
// busca_instrucao_if: instruction memory req/ack read port
// Rev 1.0
// ============================================================
`default_nettype none

interface busca_instrucao_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );
endinterface

`default_nettype wire

// File: rtl/busca_instrucao.sv
// ============================================================
// busca_instrucao: multi-cycle fetch stage (PC, IR, next-PC select)
// Rev 1.0
// ============================================================
`default_nettype none

module busca_instrucao #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 8,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15
) (
  input  wire logic               clock,
  input  wire logic               reset,
  busca_instrucao_if.master       imem,
  output logic [2:0]              OPcode,
  output logic [1:0]              BitVerificao,
  output logic [INSTR_W-1:0]      instr,
  output logic                    instr_valid,
  output logic [ADDR_W-1:0]       pc,
  input  wire logic               Jump,
  input  wire logic               Beqz,
  input  wire logic               Halt,
  input  wire logic               zero,
  input  wire logic [ADDR_W-1:0]  jump_target,
  input  wire logic               stall,
  input  wire logic               resume,
  output logic                    fetch_err
);

  localparam int                 c_CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_WAIT_LAST  = c_CNT_W'(TIMEOUT - 1);
  localparam logic [INSTR_W-1:0] c_IR_RESET   = {3'b111, {(INSTR_W-3){1'b0}}};
  localparam logic [ADDR_W-1:0]  c_PC_RESET   = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_ISSUE  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t               r_state;
  logic [ADDR_W-1:0]    r_pc;
  logic [INSTR_W-1:0]   r_ir;
  logic [c_CNT_W-1:0]   r_wait;
  logic                 r_req;
  logic                 r_valid;
  logic                 r_err;

  logic [ADDR_W-1:0]    w_offset;
  logic [ADDR_W-1:0]    w_pc_inc;
  logic [ADDR_W-1:0]    w_pc_branch;

  // Branch offset is relative to pc+1; all sums wrap modulo 2^ADDR_W
  assign w_offset    = {{(ADDR_W-4){r_ir[3]}}, r_ir[3:0]};
  assign w_pc_inc    = r_pc + ADDR_W'(1);
  assign w_pc_branch = w_pc_inc + w_offset;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_pc    <= c_PC_RESET;
      r_ir    <= c_IR_RESET;
      r_wait  <= '0;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          // Only the cycle right after reset enters here with the request low
          if (!r_req) begin
            r_req <= 1'b1;
          end else if (imem.imem_ack) begin
            r_ir    <= imem.imem_data;
            r_wait  <= '0;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= S_ISSUE;
          end else if (r_wait == c_WAIT_LAST) begin
            r_err   <= 1'b1;
            r_req   <= 1'b0;
            r_wait  <= '0;
            r_state <= S_HALTED;
          end else begin
            r_wait <= r_wait + c_CNT_W'(1);
          end
        end

        S_ISSUE: begin
          if (!stall) begin
            r_valid <= 1'b0;
            if (Halt) begin
              r_state <= S_HALTED;
            end else begin
              r_req   <= 1'b1;
              r_state <= S_FETCH;
              if (Jump)
                r_pc <= jump_target;
              else if (Beqz && zero)
                r_pc <= w_pc_branch;
              else
                r_pc <= w_pc_inc;
            end
          end
        end

        S_HALTED: begin
          if (resume) begin
            r_err   <= 1'b0;
            r_req   <= 1'b1;
            r_state <= S_FETCH;
          end
        end

        default: begin
          r_state <= S_FETCH;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_pc;
  assign OPcode         = r_ir[INSTR_W-1 -: 3];
  assign BitVerificao   = r_ir[1:0];
  assign instr          = r_ir;
  assign instr_valid    = r_valid;
  assign pc             = r_pc;
  assign fetch_err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_busca_instrucao.sv
// ============================================================
// tb_busca_instrucao: vectors, corner sequences and random model check
// Rev 1.0
// ============================================================
`default_nettype none

module tb_busca_instrucao;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] OPcode;
  logic [1:0] BitVerificao;
  logic [7:0] instr;
  logic       instr_valid;
  logic [7:0] pc;
  logic       Jump = 0, Beqz = 0, Halt = 0, zero = 0, stall = 0, resume = 0;
  logic [7:0] jump_target = 0;
  logic       fetch_err;

  int checks = 0;
  int errors = 0;

  busca_instrucao_if #(.ADDR_W(8), .INSTR_W(8)) imem_bus ();

  busca_instrucao #(
    .ADDR_W(8), .INSTR_W(8), .RESET_PC(0), .TIMEOUT(15)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .imem         (imem_bus),
    .OPcode       (OPcode),
    .BitVerificao (BitVerificao),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .Jump         (Jump),
    .Beqz         (Beqz),
    .Halt         (Halt),
    .zero         (zero),
    .jump_target  (jump_target),
    .stall        (stall),
    .resume       (resume),
    .fetch_err    (fetch_err)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [7:0] start_pc;
    logic [7:0] ins;
    logic       jmp, bqz, hlt, zro;
    logic [7:0] tgt;
    logic       exp_halt;
    logic [7:0] exp_pc;
  } vec_t;

  function automatic vec_t mk(string n, logic [7:0] p, logic [7:0] i, logic j, logic b,
                              logic h, logic z, logic [7:0] t, logic eh, logic [7:0] e);
    vec_t v;
    v.name = n; v.start_pc = p; v.ins = i; v.jmp = j; v.bqz = b; v.hlt = h;
    v.zro = z; v.tgt = t; v.exp_halt = eh; v.exp_pc = e;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic clr();
    imem_bus.imem_ack  = 1'b0;
    imem_bus.imem_data = 8'h00;
    Jump = 0; Beqz = 0; Halt = 0; zero = 0; stall = 0; resume = 0;
    jump_target = 8'h00;
  endtask

  // Returns at a negedge with imem_req high, or counts a failure after the budget
  task automatic wait_req(string name);
    int n;
    n = 0;
    while (imem_bus.imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (imem_bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL %s: imem_req never rose within 20 cycles", name);
    end
  endtask

  task automatic run_vec(vec_t v);
    wait_req({v.name, "_setup_req"});
    clr(); imem_bus.imem_ack = 1; imem_bus.imem_data = 8'h00; step();
    clr(); Jump = 1; jump_target = v.start_pc; step();
    chk({v.name, "_start_addr"}, imem_bus.imem_addr, v.start_pc);
    clr(); imem_bus.imem_ack = 1; imem_bus.imem_data = v.ins; step();
    chk({v.name, "_instr"}, instr, v.ins);
    clr(); Jump = v.jmp; Beqz = v.bqz; Halt = v.hlt; zero = v.zro; jump_target = v.tgt; step();
    clr();
    if (v.exp_halt) begin
      chk({v.name, "_halt_req"}, imem_bus.imem_req, 0);
      chk({v.name, "_halt_pc"}, pc, v.exp_pc);
      resume = 1; step(); clr();
    end
    chk({v.name, "_next_req"}, imem_bus.imem_req, 1);
    chk({v.name, "_next_addr"}, imem_bus.imem_addr, v.exp_pc);
  endtask

  vec_t vecs[9];
  logic [7:0] mem[256];

  initial begin
    logic [7:0] saved_pc;
    logic [7:0] m_pc, m_ir;
    int phase, waited, lat, hold, off;

    clr();
    vecs[0] = mk("beqz_fwd_taken",  8'h04, 8'hC2, 0, 1, 0, 1, 8'h00, 0, 8'h07);
    vecs[1] = mk("beqz_not_taken",  8'h04, 8'hC2, 0, 1, 0, 0, 8'h00, 0, 8'h05);
    vecs[2] = mk("beqz_back",       8'h04, 8'hCE, 0, 1, 0, 1, 8'h00, 0, 8'h03);
    vecs[3] = mk("jr",              8'h09, 8'hE3, 1, 0, 0, 0, 8'h40, 0, 8'h40);
    vecs[4] = mk("pc_wrap",         8'hFF, 8'h03, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    vecs[5] = mk("beqz_wrap_down",  8'h02, 8'hC8, 0, 1, 0, 1, 8'h00, 0, 8'hFB);
    vecs[6] = mk("halt_over_jump",  8'h09, 8'hE3, 1, 0, 1, 0, 8'h40, 1, 8'h09);
    vecs[7] = mk("beqz_wrap_up",    8'hF9, 8'hC7, 0, 1, 0, 1, 8'h00, 0, 8'h01);
    vecs[8] = mk("jump_over_beqz",  8'h10, 8'h00, 1, 1, 0, 1, 8'h20, 0, 8'h20);

    // Reset state
    step(); step();
    chk("rst_req", imem_bus.imem_req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_ir", instr, 8'hE0);
    chk("rst_opcode", OPcode, 3'b111);
    chk("rst_valid", instr_valid, 0);
    chk("rst_err", fetch_err, 0);
    reset = 1'b1;

    // Zero-latency ack: two instructions back to back
    wait_req("first_req");
    chk("seq_addr0", imem_bus.imem_addr, 8'h00);
    imem_bus.imem_ack = 1; imem_bus.imem_data = 8'h03; step(); clr();
    chk("seq_valid0", instr_valid, 1);
    chk("seq_op0", OPcode, 3'b000);
    chk("seq_bv0", BitVerificao, 2'b11);
    chk("seq_req_issue", imem_bus.imem_req, 0);
    step();
    chk("seq_valid_gap", instr_valid, 0);
    chk("seq_addr1", imem_bus.imem_addr, 8'h01);
    chk("seq_pc1", pc, 8'h01);
    imem_bus.imem_ack = 1; imem_bus.imem_data = 8'h05; step(); clr();
    chk("seq_valid1", instr_valid, 1);
    chk("seq_op1", OPcode, 3'b000);
    chk("seq_bv1", BitVerificao, 2'b01);
    step();
    chk("seq_addr2", imem_bus.imem_addr, 8'h02);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Ack timeout: 15 cycles without ack halts with an error
    saved_pc = pc;
    clr();
    for (int i = 1; i <= 15; i++) begin
      chk("timeout_wait_req", imem_bus.imem_req, 1);
      step();
    end
    chk("timeout_err", fetch_err, 1);
    chk("timeout_req", imem_bus.imem_req, 0);
    chk("timeout_valid", instr_valid, 0);
    for (int i = 0; i < 3; i++) begin
      imem_bus.imem_ack = 1; imem_bus.imem_data = 8'hAA; step();
      chk("halted_ignores_ack", imem_bus.imem_req, 0);
    end
    clr(); resume = 1; step(); clr();
    chk("resume_req", imem_bus.imem_req, 1);
    chk("resume_err_clr", fetch_err, 0);
    chk("resume_addr", imem_bus.imem_addr, saved_pc);

    // Ack on the 15th waiting cycle still wins
    for (int i = 1; i <= 15; i++) begin
      imem_bus.imem_ack = (i == 15); imem_bus.imem_data = 8'h5A; step();
    end
    clr();
    chk("late_ack_valid", instr_valid, 1);
    chk("late_ack_ir", instr, 8'h5A);
    chk("late_ack_err", fetch_err, 0);

    // Stall holds the issuing instruction and ignores Jump
    for (int i = 0; i < 3; i++) begin
      stall = 1; Jump = 1; jump_target = 8'h77; step();
      chk("stall_valid", instr_valid, 1);
      chk("stall_ir", instr, 8'h5A);
      chk("stall_pc", pc, saved_pc);
    end
    clr(); step();
    chk("after_stall_addr", imem_bus.imem_addr, 8'(saved_pc + 1));
    chk("after_stall_req", imem_bus.imem_req, 1);

    // Asynchronous reset in the middle of a fetch
    reset = 1'b0;
    #1;
    chk("async_rst_req", imem_bus.imem_req, 0);
    chk("async_rst_pc", pc, 0);
    chk("async_rst_ir", instr, 8'hE0);
    step();
    reset = 1'b1;

    // Randomised run against a transaction-level model of the fetch rules
    foreach (mem[i]) mem[i] = 8'($urandom);
    wait_req("rand_first_req");
    m_pc = 8'h00; m_ir = 8'h00;
    phase = 0; waited = 0; lat = 0; hold = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      clr();
      case (phase)
        0: begin
          chk("rnd_fetch_req", imem_bus.imem_req, 1);
          chk("rnd_fetch_addr", imem_bus.imem_addr, m_pc);
          chk("rnd_fetch_valid", instr_valid, 0);
          if (waited >= lat) begin
            imem_bus.imem_ack  = 1;
            imem_bus.imem_data = mem[m_pc];
            m_ir  = mem[m_pc];
            phase = 1;
          end else begin
            waited++;
          end
        end
        1: begin
          chk("rnd_issue_valid", instr_valid, 1);
          chk("rnd_issue_ir", instr, m_ir);
          chk("rnd_issue_op", OPcode, m_ir[7:5]);
          chk("rnd_issue_bv", BitVerificao, m_ir[1:0]);
          chk("rnd_issue_pc", pc, m_pc);
          chk("rnd_issue_req", imem_bus.imem_req, 0);
          stall = ($urandom_range(3) == 0);
          Halt  = ($urandom_range(9) == 0);
          Jump  = ($urandom_range(4) == 0);
          Beqz  = ($urandom_range(1) == 0);
          zero  = ($urandom_range(1) == 0);
          jump_target = 8'($urandom);
          imem_bus.imem_ack  = ($urandom_range(1) == 0);
          imem_bus.imem_data = 8'($urandom);
          if (!stall) begin
            if (Halt) begin
              phase = 2;
              hold  = $urandom_range(3);
            end else begin
              if (Jump) begin
                m_pc = jump_target;
              end else if (Beqz && zero) begin
                off = int'(m_ir[3:0]);
                if (off > 7) off = off - 16;
                m_pc = 8'(int'(m_pc) + 1 + off);
              end else begin
                m_pc = 8'(int'(m_pc) + 1);
              end
              phase  = 0;
              waited = 0;
              lat    = $urandom_range(4);
            end
          end
        end
        default: begin
          chk("rnd_halt_req", imem_bus.imem_req, 0);
          chk("rnd_halt_valid", instr_valid, 0);
          chk("rnd_halt_pc", pc, m_pc);
          chk("rnd_halt_err", fetch_err, 0);
          imem_bus.imem_ack = ($urandom_range(1) == 0);
          if (hold == 0) begin
            resume = 1;
            phase  = 0;
            waited = 0;
            lat    = $urandom_range(4);
          end else begin
            hold--;
          end
        end
      endcase
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
